// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  tx_data;
  logic        tx_start_req;
  logic        tx_start_ack;
  logic        busy;
  logic        err;

  // Requesters and the UART transmitter side
  modport master (
    output req, data_in, tx_start_ack,
    input  gnt, gnt_id, tx_data, tx_start_req, busy, err
  );

  // Arbiter side
  modport slave (
    input  req, data_in, tx_start_ack,
    output gnt, gnt_id, tx_data, tx_start_req, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART transmitter with req/ack start handshake
module uart_tx_arbiter #(
  parameter int FRAME_CYCLES = 2780,
  parameter int ACK_TIMEOUT  = 4096
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int MAX_CYCLES = (FRAME_CYCLES > ACK_TIMEOUT) ? FRAME_CYCLES : ACK_TIMEOUT;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_ACK_LOW, GUARD} state_t;

  state_t        state, state_d;
  logic [1:0]    ptr, ptr_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_req_q, tx_req_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          ack_meta, ack_s;
  logic          found;
  logic [1:0]    winner;

  // Bring the baud-domain acknowledge into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus.tx_start_ack;
      ack_s    <= ack_meta;
    end
  end

  // First pending requester at or after the priority pointer, wrapping 3->0
  always_comb begin
    logic [1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and next-output logic; every output is taken from a register
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gnt_d     = '0;
    gnt_id_d  = gnt_id_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    err_d     = 1'b0;
    cnt_d     = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_d = bus.data_in[{winner, 3'b000} +: 8];
          gnt_d     = 4'b0001 << winner;
          gnt_id_d  = winner;
          ptr_d     = winner + 2'd1;
          tx_req_d  = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          tx_req_d = 1'b0;
          state_d  = WAIT_ACK_LOW;
        end else if (cnt == ACK_LAST) begin
          // The byte is dropped; the requester already saw its grant
          tx_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_s) begin
          cnt_d   = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt == FRAME_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any handshake without pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      cnt       <= cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_id       = gnt_id_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start_req = tx_req_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int FRAME   = 20;
  localparam int TMO     = 16;
  localparam int ACK_DLY = 5;
  localparam int SPACING = ACK_DLY + 7 + FRAME;

  logic clk = 1'b0;
  logic rst;
  logic ack_en;
  int   total = 0;
  int   bad   = 0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.FRAME_CYCLES(FRAME), .ACK_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Steps at least one negedge, then until a grant is seen or limit expires
  task automatic wait_gnt(input int limit, output int id, output int dt);
    dt = 0;
    do begin
      @(negedge clk);
      dt++;
    end while (bus.gnt == 4'b0000 && dt < limit);
    case (bus.gnt)
      4'b0001: id = 0;
      4'b0010: id = 1;
      4'b0100: id = 2;
      4'b1000: id = 3;
      default: id = -1;
    endcase
  endtask

  task automatic wait_idle(input int limit, output int dt);
    dt = 0;
    do begin
      @(negedge clk);
      dt++;
    end while (bus.busy && dt < limit);
  endtask

  // UART transmitter model: ack ACK_DLY cycles after a start request, release once it drops
  initial begin
    bus.tx_start_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && bus.tx_start_req) begin
        repeat (ACK_DLY) @(negedge clk);
        bus.tx_start_ack = 1'b1;
        while (bus.tx_start_req) @(negedge clk);
        bus.tx_start_ack = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int id, dt, n;
    rst = 1'b1;
    ack_en = 1'b1;
    bus.req = 4'b0000;
    bus.data_in = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_tx_req", 32'(bus.tx_start_req), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_gnt", 32'(bus.gnt), 32'h0);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // Single request
    bus.data_in = 32'h0000_0055;
    bus.req = 4'b0001;
    wait_gnt(10, id, dt);
    bus.req = 4'b0000;
    check("single_lat", 32'(dt), 32'd1);
    check("single_id", 32'(id), 32'd0);
    check("single_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("single_data", 32'(bus.tx_data), 32'h55);
    check("single_tx_req", 32'(bus.tx_start_req), 32'd1);
    check("single_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    n = 1;
    check("single_gnt_pulse", 32'(bus.gnt), 32'h0);
    while (bus.tx_start_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("single_req_drop", 32'(n), 32'(ACK_DLY + 3));
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("single_busy_len", 32'(n), 32'(ACK_DLY + 6 + FRAME));
    check("single_data_hold", 32'(bus.tx_data), 32'h55);

    // Round robin from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.data_in = 32'hA3A2_A1A0;
    bus.req = 4'b1111;
    wait_gnt(10, id, dt);
    check("rr0_id", 32'(id), 32'd0);
    check("rr0_data", 32'(bus.tx_data), 32'hA0);
    for (int k = 1; k < 5; k++) begin
      wait_gnt(200, id, dt);
      check("rr_id", 32'(id), 32'(k % 4));
      check("rr_gnt_id", 32'(bus.gnt_id), 32'(k % 4));
      check("rr_data", 32'(bus.tx_data), 32'hA0 + 32'(k % 4));
      check("rr_spacing", 32'(dt), 32'(SPACING));
    end
    bus.req = 4'b0000;
    wait_idle(200, dt);

    // Pointer wrap: grant 2, then 3 wins over 0, then 0
    bus.data_in = 32'h4433_2211;
    bus.req = 4'b0100;
    wait_gnt(10, id, dt);
    bus.req = 4'b0000;
    check("wrap_first", 32'(id), 32'd2);
    wait_idle(200, dt);
    bus.req = 4'b1001;
    wait_gnt(10, id, dt);
    check("wrap_3", 32'(id), 32'd3);
    check("wrap_3_data", 32'(bus.tx_data), 32'h44);
    wait_gnt(200, id, dt);
    bus.req = 4'b0000;
    check("wrap_0", 32'(id), 32'd0);
    check("wrap_0_data", 32'(bus.tx_data), 32'h11);
    wait_idle(200, dt);

    // Acknowledge timeout
    ack_en = 1'b0;
    bus.data_in = 32'h0077_0000;
    bus.req = 4'b0100;
    wait_gnt(10, id, dt);
    bus.req = 4'b0000;
    check("tmo_id", 32'(id), 32'd2);
    check("tmo_data", 32'(bus.tx_data), 32'h77);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.err && n < 100);
    check("tmo_err_delay", 32'(n), 32'(TMO));
    check("tmo_tx_req", 32'(bus.tx_start_req), 32'd0);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("tmo_err_pulse", 32'(bus.err), 32'd0);
    ack_en = 1'b1;

    // Late request arriving during GUARD
    bus.data_in = 32'h0000_3C01;
    bus.req = 4'b0001;
    wait_gnt(10, id, dt);
    bus.req = 4'b0000;
    check("late_first", 32'(id), 32'd0);
    repeat (ACK_DLY + 10) @(negedge clk);
    bus.req = 4'b0010;
    wait_gnt(200, id, dt);
    check("late_id", 32'(id), 32'd1);
    check("late_wait", 32'(dt), 32'(FRAME - 3));

    // Reset mid-GUARD with requester 1 still pending
    repeat (ACK_DLY + 10) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    check("mid_rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("mid_rst_tx_req", 32'(bus.tx_start_req), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    check("mid_rst_err", 32'(bus.err), 32'h0);
    check("mid_rst_gnt_hold", 32'(bus.gnt), 32'h0);
    rst = 1'b0;
    wait_gnt(10, id, dt);
    bus.req = 4'b0000;
    check("post_rst_lat", 32'(dt), 32'd1);
    check("post_rst_id", 32'(id), 32'd1);
    check("post_rst_data", 32'(bus.tx_data), 32'h3C);
    wait_idle(200, dt);
    check("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
